fft_block_framer: RTL

Parametrised serial-to-parallel framer that sits directly in front of `fft_top`. It collects a stream of one complex sample per accepted cycle into blocks of `N` samples and presents each completed block as flattened `din_re`/`din_im` vectors with a single-cycle `valid` strobe. It generalises the fixed 16-point, 9-bit block feed to any power-of-two block size and sample width. It adds frame alignment on a start-of-frame marker, short-frame error reporting and an emitted-block counter.

---
 rtl/fft_block_framer.sv | 115 +++++++++++
 1 files changed

// File: rtl/fft_block_framer.sv
// rtl/fft_block_framer.sv - serial-to-parallel complex block framer feeding fft_top (optional FFT_FRAMER_BITREV_EN)
module fft_block_framer #(
    parameter int WIDTH = 9,
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic [0:WIDTH*N-1]      din_re,
    output logic [0:WIDTH*N-1]      din_im,
    output logic                    valid,
    output logic                    frame_err,
    output logic [CNT_W-1:0]        blk_cnt
);

    localparam int LOGN = $clog2(N);
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    typedef logic signed [WIDTH-1:0] samp_t;

    samp_t              shadow_re_q [N];
    samp_t              shadow_re_d [N];
    samp_t              shadow_im_q [N];
    samp_t              shadow_im_d [N];
    logic [LOGN-1:0]    wr_cnt_q, wr_cnt_d;
    logic [LOGN-1:0]    wr_addr;
    logic [0:WIDTH*N-1] din_re_q, din_re_d;
    logic [0:WIDTH*N-1] din_im_q, din_im_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

    // Physical shadow slot for a logical sample index: identity, or bit reversal for DIT cores
    function automatic logic [LOGN-1:0] addr_of(input logic [LOGN-1:0] idx);
        logic [LOGN-1:0] r;
`ifdef FFT_FRAMER_BITREV_EN
        for (int b = 0; b < LOGN; b++) begin
            r[b] = idx[LOGN-1-b];
        end
`else
        r = idx;
`endif
        return r;
    endfunction

    // Next-state: write accepted sample, handle resync on sof, publish full blocks
    always_comb begin
        shadow_re_d = shadow_re_q;
        shadow_im_d = shadow_im_q;
        wr_cnt_d    = wr_cnt_q;
        din_re_d    = din_re_q;
        din_im_d    = din_im_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        blk_cnt_d   = blk_cnt_q;
        // a sof sample is logical index 0, which maps to physical slot 0 in both orders
        wr_addr     = in_sof ? '0 : addr_of(wr_cnt_q);

        if (in_valid) begin
            shadow_re_d[wr_addr] = in_re;
            shadow_im_d[wr_addr] = in_im;
            if (in_sof) begin
                // sof takes priority over completion; a partly filled frame is dropped
                wr_cnt_d    = LOGN'(1);
                frame_err_d = (wr_cnt_q != '0);
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == LAST_IDX) begin
                    valid_d   = 1'b1;
                    blk_cnt_d = blk_cnt_q + 1'b1;
                    for (int m = 0; m < N; m++) begin
                        din_re_d[m*WIDTH +: WIDTH] = shadow_re_d[m];
                        din_im_d[m*WIDTH +: WIDTH] = shadow_im_d[m];
                    end
                end
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < N; m++) begin
                shadow_re_q[m] <= '0;
                shadow_im_q[m] <= '0;
            end
            wr_cnt_q    <= '0;
            din_re_q    <= '0;
            din_im_q    <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            shadow_re_q <= shadow_re_d;
            shadow_im_q <= shadow_im_d;
            wr_cnt_q    <= wr_cnt_d;
            din_re_q    <= din_re_d;
            din_im_q    <= din_im_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign din_re    = din_re_q;
    assign din_im    = din_im_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign blk_cnt   = blk_cnt_q;

endmodule
